// File: rtl/pipe_rr_arbiter_if.sv
// Valid/ready channel bundle for pipe_rr_arbiter: NUM_REQ requester lanes in,
// one registered output lane out.
interface pipe_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]              out_src;
  logic                          out_last;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin N-to-1 packet arbiter feeding a one-entry registered output stage;
// the grant stays locked on a requester from its first beat until its last beat.
module pipe_rr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter bit FULL_THROUGHPUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  pipe_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_r;
  logic [IDX_W-1:0]      lock_idx_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic                  full_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [IDX_W-1:0]      src_r;
  logic                  last_r;

  logic [NUM_REQ-1:0]    grant_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic                  grant_hit_s;
  logic                  wr_en_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic                  xfer_s;
  logic                  beat_last_s;
  logic [DATA_WIDTH-1:0] beat_data_s;
  logic [IDX_W-1:0]      next_ptr_s;

  // Grant selection: locked requester, else first valid at or after rr_ptr (two passes give the wrap).
  always_comb begin
    logic take_s;
    take_s      = 1'b0;
    grant_hit_s = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    grant_s     = {NUM_REQ{1'b0}};
    if (state_r == ST_LOCKED) begin
      grant_hit_s = 1'b1;
      grant_idx_s = lock_idx_r;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        take_s      = !grant_hit_s && bus.req_valid[i] && (IDX_W'(i) >= rr_ptr_r);
        grant_hit_s = grant_hit_s | take_s;
        grant_idx_s = take_s ? IDX_W'(i) : grant_idx_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        take_s      = !grant_hit_s && bus.req_valid[i] && (IDX_W'(i) < rr_ptr_r);
        grant_hit_s = grant_hit_s | take_s;
        grant_idx_s = take_s ? IDX_W'(i) : grant_idx_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = grant_hit_s && (grant_idx_s == IDX_W'(i));
    end
  end

  // Handshake and winning-beat mux; one-hot grant lets an AND-OR tree replace a variable index.
  always_comb begin
    wr_en_s     = FULL_THROUGHPUT ? (bus.out_ready | ~full_r) : ~full_r;
    req_ready_s = grant_s & {NUM_REQ{wr_en_s}};
    xfer_s      = |(bus.req_valid & req_ready_s);
    beat_last_s = |(bus.req_last & grant_s);
    beat_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_data_s = beat_data_s | (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
    end
    next_ptr_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (grant_idx_s + IDX_W'(1));
  end

  // Output stage, packet lock FSM and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
      full_r     <= 1'b0;
      data_r     <= {DATA_WIDTH{1'b0}};
      src_r      <= {IDX_W{1'b0}};
      last_r     <= 1'b0;
    end else begin
      if (wr_en_s) begin
        full_r <= xfer_s;
        if (xfer_s) begin
          data_r <= beat_data_s;
          src_r  <= grant_idx_s;
          last_r <= beat_last_s;
        end
      end else if (bus.out_ready) begin
        // Only reachable without the ready bypass: drain now, refill next cycle.
        full_r <= 1'b0;
      end
      if (xfer_s) begin
        case (state_r)
          ST_IDLE: begin
            if (beat_last_s) begin
              rr_ptr_r <= next_ptr_s;
            end else begin
              state_r    <= ST_LOCKED;
              lock_idx_r <= grant_idx_s;
            end
          end
          ST_LOCKED: begin
            if (beat_last_s) begin
              state_r  <= ST_IDLE;
              rr_ptr_r <= next_ptr_s;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = full_r;
  assign bus.out_data  = data_r;
  assign bus.out_src   = src_r;
  assign bus.out_last  = last_r;
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter: a 4-requester full-throughput instance
// and a 3-requester half-throughput instance, checked against hand-computed vectors.
module tb_pipe_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus4 ();
  pipe_rr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(16)) bus3 ();

  pipe_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .FULL_THROUGHPUT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  pipe_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .FULL_THROUGHPUT(1'b0)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus4.req_valid = 4'b0000; bus4.req_last = 4'b0000; bus4.req_data = 64'h0; bus4.out_ready = 1'b1;
    bus3.req_valid = 3'b000;  bus3.req_last = 3'b000;  bus3.req_data = 48'h0; bus3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus4.out_valid, 32'd0);
    check_eq("rst_out_data", bus4.out_data, 32'd0);
    check_eq("rst_out_src", bus4.out_src, 32'd0);
    check_eq("rst_out_last", bus4.out_last, 32'd0);
    check_eq("rst_rr_ptr", dut4.rr_ptr_r, 32'd0);
    rst = 1'b0;

    // All four requesters, single-beat packets: 0,1,2,3,0 back to back.
    bus4.req_valid = 4'b1111;
    bus4.req_last  = 4'b1111;
    bus4.req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    #1 check_eq("t1_ready_first", bus4.req_ready, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t1_out_valid", bus4.out_valid, 32'd1);
      check_eq("t1_out_src", bus4.out_src, 32'(k % 4));
      check_eq("t1_out_data", bus4.out_data, 32'h1000 + 32'(k % 4));
    end
    bus4.req_valid = 4'b0000;
    tick();
    check_eq("t1_drain", bus4.out_valid, 32'd0);

    // rr_ptr=1: requester 1 sends 3 beats while 0 and 2 wait.
    bus4.req_valid = 4'b0111;
    bus4.req_last  = 4'b0101;
    bus4.req_data  = {16'h0000, 16'h2200, 16'h2001, 16'h2100};
    #1 check_eq("t2_ready_b1", bus4.req_ready, 32'h2);
    tick();
    check_eq("t2_src_b1", bus4.out_src, 32'd1);
    check_eq("t2_data_b1", bus4.out_data, 32'h2001);
    check_eq("t2_last_b1", bus4.out_last, 32'd0);
    bus4.req_data[16 +: 16] = 16'h2002;
    #1 check_eq("t2_ready_b2", bus4.req_ready, 32'h2);
    tick();
    check_eq("t2_src_b2", bus4.out_src, 32'd1);
    check_eq("t2_data_b2", bus4.out_data, 32'h2002);
    bus4.req_data[16 +: 16] = 16'h2003;
    bus4.req_last = 4'b0111;
    #1 check_eq("t2_ready_b3", bus4.req_ready, 32'h2);
    tick();
    check_eq("t2_src_b3", bus4.out_src, 32'd1);
    check_eq("t2_data_b3", bus4.out_data, 32'h2003);
    check_eq("t2_last_b3", bus4.out_last, 32'd1);
    bus4.req_valid = 4'b0101;
    #1 check_eq("t2_ready_r2", bus4.req_ready, 32'h4);
    tick();
    check_eq("t2_src_r2", bus4.out_src, 32'd2);
    check_eq("t2_data_r2", bus4.out_data, 32'h2200);
    #1 check_eq("t2_ready_r0", bus4.req_ready, 32'h1);
    tick();
    check_eq("t2_src_r0", bus4.out_src, 32'd0);
    check_eq("t2_data_r0", bus4.out_data, 32'h2100);
    bus4.req_valid = 4'b0000;
    tick();
    check_eq("t2_drain", bus4.out_valid, 32'd0);

    // Stall: 0xABCD held for 3 cycles with out_ready low.
    bus4.out_ready = 1'b0;
    bus4.req_valid = 4'b0010;
    bus4.req_last  = 4'b0010;
    bus4.req_data[16 +: 16] = 16'hABCD;
    #1 check_eq("t3_ready_empty", bus4.req_ready, 32'h2);
    tick();
    check_eq("t3_data_load", bus4.out_data, 32'hABCD);
    bus4.req_valid = 4'b1000;
    bus4.req_last  = 4'b1000;
    bus4.req_data[48 +: 16] = 16'h3333;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("t3_stall_ready", bus4.req_ready, 32'h0);
      tick();
      check_eq("t3_stall_valid", bus4.out_valid, 32'd1);
      check_eq("t3_stall_data", bus4.out_data, 32'hABCD);
      check_eq("t3_stall_ptr", dut4.rr_ptr_r, 32'd2);
    end
    bus4.out_ready = 1'b1;
    #1 check_eq("t3_release_ready", bus4.req_ready, 32'h8);
    tick();
    check_eq("t3_src_after", bus4.out_src, 32'd3);
    check_eq("t3_data_after", bus4.out_data, 32'h3333);
    bus4.req_valid = 4'b0000;
    tick();

    // Reset in the middle of a locked packet from requester 0.
    bus4.req_valid = 4'b0001;
    bus4.req_last  = 4'b0000;
    bus4.req_data[0 +: 16] = 16'h4000;
    #1 check_eq("t6_ready_b1", bus4.req_ready, 32'h1);
    tick();
    bus4.req_data[0 +: 16] = 16'h4001;
    tick();
    check_eq("t6_data_b2", bus4.out_data, 32'h4001);
    rst = 1'b1;
    #1 check_eq("t6_rst_valid", bus4.out_valid, 32'd0);
    check_eq("t6_rst_data", bus4.out_data, 32'd0);
    #1 rst = 1'b0;
    bus4.req_valid = 4'b1000;
    bus4.req_last  = 4'b1000;
    bus4.req_data[48 +: 16] = 16'h5000;
    #1 check_eq("t6_ready_r3", bus4.req_ready, 32'h8);
    tick();
    check_eq("t6_src_r3", bus4.out_src, 32'd3);
    check_eq("t6_valid_r3", bus4.out_valid, 32'd1);
    check_eq("t6_data_r3", bus4.out_data, 32'h5000);
    bus4.req_valid = 4'b0000;
    tick();

    // Half-throughput instance, requester 0 streams 4 single-beat packets.
    for (int c = 0; c < 8; c++) begin
      bus3.req_valid = (c < 7) ? 3'b001 : 3'b000;
      bus3.req_last  = 3'b001;
      bus3.req_data[0 +: 16] = 16'h0A00 + 16'(c / 2);
      #1 check_eq("t4_ready", bus3.req_ready, (c % 2 == 0 && c < 7) ? 32'h1 : 32'h0);
      tick();
      check_eq("t4_out_valid", bus3.out_valid, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) begin
        check_eq("t4_out_data", bus3.out_data, 32'h0A00 + 32'(c / 2));
      end
    end

    // NUM_REQ=3: completion on requester 2 wraps the pointer to 0.
    bus3.req_valid = 3'b100;
    bus3.req_last  = 3'b100;
    bus3.req_data[32 +: 16] = 16'h0C02;
    #1 check_eq("t5_ready_r2", bus3.req_ready, 32'h4);
    tick();
    check_eq("t5_src_r2", bus3.out_src, 32'd2);
    check_eq("t5_ptr_wrap", dut3.rr_ptr_r, 32'd0);
    bus3.req_valid = 3'b101;
    bus3.req_last  = 3'b101;
    bus3.req_data[0 +: 16] = 16'h0C00;
    #1 check_eq("t5_ready_full", bus3.req_ready, 32'h0);
    tick();
    check_eq("t5_drained", bus3.out_valid, 32'd0);
    #1 check_eq("t5_ready_r0", bus3.req_ready, 32'h1);
    tick();
    check_eq("t5_src_r0", bus3.out_src, 32'd0);
    check_eq("t5_data_r0", bus3.out_data, 32'h0C00);
    bus3.req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
